// File: rtl/score_display.sv
// Four-digit multiplexed 7-segment score display with frame-synchronous input shadowing.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero tens digits for both players.
module score_display #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned GUARD_CYC   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] leftscoreLeft,
   input  logic [3:0] leftscoreRight,
   input  logic [3:0] rightscoreLeft,
   input  logic [3:0] rightscoreRight,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [CW-1:0]  cnt_q, cnt_d;
   logic [1:0]     idx_q, idx_d;
   // Entry i holds the digit shown while idx == i.
   logic [3:0][3:0] shadow_q;
   logic           wrap;
   logic [3:0]     cur;
   logic [6:0]     seg_d;
   logic [3:0]     an_d;
   logic           dp_d;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      unique case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   always_comb begin
      wrap  = (cnt_q == CW'(REFRESH_DIV - 1));
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      idx_d = wrap ? idx_q - 2'd1 : idx_q;
      cur   = shadow_q[idx_q];
      seg_d = decode(cur);
`ifdef LEADING_ZERO_BLANK_EN
      if ((idx_q == 2'd3 || idx_q == 2'd1) && cur == 4'd0) seg_d = 7'b1111111;
`else
      seg_d = seg_d;
`endif
      // Guard window keeps all anodes dark while segments settle (anti-ghosting).
      an_d  = (cnt_q < CW'(GUARD_CYC)) ? 4'b1111 : ~(4'b0001 << idx_q);
      dp_d  = (idx_q != 2'd2);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         idx_q    <= 2'd3;
         shadow_q <= '0;
         seg      <= 7'b1111111;
         dp       <= 1'b1;
         an       <= 4'b1111;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         if (wrap && idx_q == 2'd0) begin
            shadow_q[3] <= leftscoreLeft;
            shadow_q[2] <= leftscoreRight;
            shadow_q[1] <= rightscoreLeft;
            shadow_q[0] <= rightscoreRight;
         end
         seg <= seg_d;
         dp  <= dp_d;
         an  <= an_d;
      end
   end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clocks per digit slot (≥ GUARD_CYC+2).
REQ-002 SHALL have parameter GUARD_CYC, default 2, clocks at slot start with all anodes off (anti-ghosting).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port leftscoreLeft  input  4  left player tens digit.
REQ-006 SHALL have port leftscoreRight  input  4  left player units digit.
REQ-007 SHALL have port rightscoreLeft  input  4  right player tens digit.
REQ-008 SHALL have port rightscoreRight  input  4  right player units digit.
REQ-009 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active low.
REQ-010 SHALL have port dp  output  1  decimal point, active low.
REQ-011 SHALL have port an  output  4  digit anodes, active low; an[3] leftmost.

Function
REQ-012 Slot counter SHALL count 0..REFRESH_DIV-1, then wrap to 0; index SHALL advance 3->2->1->0->3 on wrap.
REQ-013 Digit mapping SHALL be: index 3 leftscoreLeft, 2 leftscoreRight, 1 rightscoreLeft, 0 rightscoreRight.
REQ-014 All four inputs SHALL be captured into a shadow register when counter wraps while index==0 (frame boundary); display SHALL use shadow only, never live inputs (no tearing mid-frame).
REQ-015 Input change mid-frame SHALL appear only from the next frame (index 3) onward.
REQ-016 seg, dp, an SHALL be registered; they reflect counter/index/shadow of the previous clock (1-cycle latency).
REQ-017 While counter < GUARD_CYC, an SHALL be 4'b1111; otherwise an SHALL be low only at bit index.
REQ-018 Decode: 0->1000000, 1->1111001, 2->0100100, 3->0110000, 4->0011001, 5->0010010, 6->0000010, 7->1111000, 8->0000000, 9->0010000.
REQ-019 Codes 10..15 SHALL display dash 0111111 (invalid BCD indication).
REQ-020 dp SHALL be 0 while index==2 (player separator), 1 otherwise.
REQ-021 Shadow values 9/9 (underflow result from scoreboard) SHALL display normally as "99".

Reset
REQ-022 On reset: counter 0, index 3, shadow all 0.
REQ-023 On reset outputs SHALL be an=1111, seg=1111111, dp=1 in the following cycle.
REQ-024 Reset mid-slot SHALL abort the slot; the first cycle after release SHALL start a guard period of slot index 3.
REQ-025 Reset SHALL dominate any simultaneous counter wrap or shadow load.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN: when defined, digit at index 3 (resp. 1) SHALL show seg=1111111 when shadow leftscoreLeft (resp. rightscoreLeft)==0; anode timing unchanged.
REQ-027 Without LEADING_ZERO_BLANK_EN, zero tens digits SHALL display as 1000000.

Verification (REFRESH_DIV=4, GUARD_CYC=1)
REQ-028 Reset 2 cycles, release -> an=1111 during reset echo; an sequence per slot: 1111,0111,0111,0111 then 1111,1011,... with seg=1000000.
REQ-029 Inputs 3,4,1,2 held from reset -> after first frame boundary, slots show 0110000,0011001(dp=0),1111001,0100100.
REQ-030 Change leftscoreRight 4->5 during index 2 slot -> current frame still shows 0011001; next frame index 2 shows 0010010.
REQ-031 Input rightscoreRight=12 -> index 0 slot seg=0111111.
REQ-032 leftscoreLeft=0, rightscoreLeft=0 -> with LEADING_ZERO_BLANK_EN index 3/1 seg=1111111; without, seg=1000000.
REQ-033 Assert reset during index 1 slot, release -> next non-guard anode is an=0111, shadow reads 0 until next frame boundary.
